// File: rtl/fft_uart_pkg.sv
// Shared types and constants for the FFT-to-UART byte framer.
package fft_uart_pkg;

    localparam logic [7:0]  HEADER_DEFAULT   = 8'hAA;
    localparam int unsigned BYTES_PER_SAMPLE = 4;
    localparam int unsigned SAMPLE_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_BYTE,
        ST_WAIT,
        ST_WAIT_SAMPLE,
        ST_CSUM,
        ST_DONE
    } state_t;

    // What kind of byte is currently in flight at the transmitter
    typedef enum logic [1:0] {
        K_HDR,
        K_PAYLOAD,
        K_CSUM
    } kind_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } sample_t;

endpackage

// File: rtl/fft_uart_framer.sv
// Packs N_POINTS complex samples into a header + payload (+ checksum) byte frame
// paced by the UART transmitter handshake. Checksum byte: FFT_UART_FRAMER_CHECKSUM_EN.
module fft_uart_framer
    import fft_uart_pkg::*;
#(
    parameter int unsigned N_POINTS = 16,
    parameter logic [7:0]  HEADER   = HEADER_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [SAMPLE_W-1:0] s_re_i,
    input  logic [SAMPLE_W-1:0] s_im_i,
    output logic                tx_en_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_done_i,
    output logic                busy_o,
    output logic                frame_done_o
);

    localparam int unsigned CNT_W  = $clog2(N_POINTS + 1);
    localparam int unsigned IDX_W  = $clog2(BYTES_PER_SAMPLE);
    localparam int unsigned WORD_W = 2 * SAMPLE_W;

    state_t              state, state_n;
    kind_t               kind, kind_n;
    sample_t             hold, hold_n;
    logic                full, full_n;
    logic [WORD_W-1:0]   shift, shift_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                tx_en_n, busy_n, frame_done_n, ready_n;
    logic [7:0]          tx_data_n;
    logic                accept_c;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
    logic [7:0]          csum, csum_n;
`endif

    assign accept_c = s_valid_i && s_ready_o;

    // Next-state and registered-output decode
    always_comb begin
        state_n      = state;
        kind_n       = kind;
        hold_n       = hold;
        full_n       = full;
        shift_n      = shift;
        idx_n        = idx;
        cnt_n        = cnt;
        tx_en_n      = 1'b0;
        tx_data_n    = tx_data_o;
        frame_done_n = 1'b0;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
        csum_n       = csum;
`endif

        if (accept_c) begin
            hold_n = '{re: s_re_i, im: s_im_i};
            full_n = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (full) state_n = ST_HDR;
            end
            ST_HDR: begin
                tx_en_n   = 1'b1;
                tx_data_n = HEADER;
                kind_n    = K_HDR;
                state_n   = ST_WAIT;
            end
            ST_LOAD: begin
                shift_n = hold;
                full_n  = 1'b0;
                idx_n   = '0;
                state_n = ST_BYTE;
            end
            ST_BYTE: begin
                tx_en_n   = 1'b1;
                tx_data_n = shift[WORD_W-1 -: 8];
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                csum_n    = csum + shift[WORD_W-1 -: 8];
`endif
                kind_n    = K_PAYLOAD;
                state_n   = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_i) begin
                    case (kind)
                        K_HDR: state_n = full ? ST_LOAD : ST_WAIT_SAMPLE;
                        K_PAYLOAD: begin
                            if (idx != IDX_W'(BYTES_PER_SAMPLE - 1)) begin
                                shift_n = {shift[WORD_W-9:0], 8'h00};
                                idx_n   = idx + IDX_W'(1);
                                state_n = ST_BYTE;
                            end else begin
                                cnt_n = cnt + CNT_W'(1);
                                if (cnt_n == CNT_W'(N_POINTS)) begin
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                                    state_n = ST_CSUM;
`else
                                    state_n = ST_DONE;
`endif
                                end else begin
                                    state_n = full ? ST_LOAD : ST_WAIT_SAMPLE;
                                end
                            end
                        end
                        default: state_n = ST_DONE;
                    endcase
                end
            end
            ST_WAIT_SAMPLE: begin
                if (full) state_n = ST_LOAD;
            end
            ST_CSUM: begin
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                tx_en_n   = 1'b1;
                tx_data_n = csum;
                kind_n    = K_CSUM;
                state_n   = ST_WAIT;
`else
                state_n   = ST_DONE;
`endif
            end
            ST_DONE: begin
                frame_done_n = 1'b1;
                cnt_n        = '0;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
                csum_n       = '0;
`endif
                state_n      = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Ready follows the holding flag one cycle later, so a LOAD never accepts in the same cycle
        ready_n = !full_n;
        busy_n  = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            kind         <= K_HDR;
            hold         <= '0;
            full         <= 1'b0;
            shift        <= '0;
            idx          <= '0;
            cnt          <= '0;
            tx_en_o      <= 1'b0;
            tx_data_o    <= 8'h00;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            s_ready_o    <= 1'b1;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state        <= state_n;
            kind         <= kind_n;
            hold         <= hold_n;
            full         <= full_n;
            shift        <= shift_n;
            idx          <= idx_n;
            cnt          <= cnt_n;
            tx_en_o      <= tx_en_n;
            tx_data_o    <= tx_data_n;
            busy_o       <= busy_n;
            frame_done_o <= frame_done_n;
            s_ready_o    <= ready_n;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
            csum         <= csum_n;
`endif
        end
    end

endmodule

// File: tb/tb_fft_uart_framer.sv
// Scoreboard bench for fft_uart_framer (N_POINTS = 2) with a behavioural UART transmitter;
// expectations follow FFT_UART_FRAMER_CHECKSUM_EN.
module tb_fft_uart_framer;

    localparam int DONE_DLY = 20;
`ifdef FFT_UART_FRAMER_CHECKSUM_EN
    localparam int FRAME_LEN = 10;
`else
    localparam int FRAME_LEN = 9;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [15:0] s_re_i;
    logic [15:0] s_im_i;
    logic        tx_en_o;
    logic [7:0]  tx_data_o;
    logic        tx_done_i;
    logic        busy_o;
    logic        frame_done_o;

    always #5 clk = ~clk;

    fft_uart_framer #(.N_POINTS(2), .HEADER(8'hAA)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_re_i       (s_re_i),
        .s_im_i       (s_im_i),
        .tx_en_o      (tx_en_o),
        .tx_data_o    (tx_data_o),
        .tx_done_i    (tx_done_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];
    logic [7:0] frame_bytes [0:9];
    int         en_cnt = 0, done_cnt = 0, fd_cnt = 0;
    logic       pend, spur_after, spur_now, spur_req, prev_en, prev_fd;
    int         dly;
    int         e0, d0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(frame_bytes[i]);
    endtask

    // Offer one sample at a negedge; returns at the negedge after the accepting posedge
    task automatic send(input logic [15:0] re, input logic [15:0] im);
        s_re_i    = re;
        s_im_i    = im;
        s_valid_i = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (s_ready_o) break;
            @(negedge clk);
        end
        check("accept_ready", 32'(s_ready_o), 32'd1);
        @(negedge clk);
        s_valid_i = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < 3000; k++) begin
            if (fd_cnt >= n) break;
            @(negedge clk);
        end
        check("frame_count", 32'(fd_cnt), 32'(n));
    endtask

    initial begin
        frame_bytes[0] = 8'hAA; frame_bytes[1] = 8'h12; frame_bytes[2] = 8'h34;
        frame_bytes[3] = 8'hAB; frame_bytes[4] = 8'hCD; frame_bytes[5] = 8'h00;
        frame_bytes[6] = 8'h01; frame_bytes[7] = 8'hFF; frame_bytes[8] = 8'hFF;
        frame_bytes[9] = 8'hBD;
        rst = 1'b1; s_valid_i = 1'b0; s_re_i = '0; s_im_i = '0; tx_done_i = 1'b0;
        pend = 1'b0; spur_after = 1'b0; spur_now = 1'b0; spur_req = 1'b0;
        prev_en = 1'b0; prev_fd = 1'b0; dly = 0;

        // Transmitter model plus output monitor
        fork
            forever begin
                @(negedge clk);
                tx_done_i = 1'b0;
                if (rst) begin
                    pend     = 1'b0;
                    spur_now = 1'b0;
                end else if (tx_en_o) begin
                    check("en_while_in_flight", 32'(pend), 32'd0);
                    pend = 1'b1;
                    dly  = DONE_DLY;
                end else if (pend) begin
                    dly--;
                    if (dly == 0) begin
                        tx_done_i = 1'b1;
                        pend      = 1'b0;
                        done_cnt++;
                        spur_now  = spur_after;
                    end
                end else if (spur_now || spur_req) begin
                    tx_done_i = 1'b1;
                    spur_now  = 1'b0;
                    spur_req  = 1'b0;
                end

                if (tx_en_o) begin
                    en_cnt++;
                    check("en_pulse_width", 32'(prev_en), 32'd0);
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_byte: got %02h expected none", tx_data_o);
                    end else begin
                        check("tx_byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
                    end
                end
                if (frame_done_o) begin
                    fd_cnt++;
                    check("frame_end_pending", 32'(exp_q.size()), 32'd0);
                    check("frame_done_width", 32'(prev_fd), 32'd0);
                end
                prev_en = tx_en_o;
                prev_fd = frame_done_o;
            end
        join_none

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(s_ready_o), 32'd1);
        check("rst_en",    32'(tx_en_o),   32'd0);
        check("rst_data",  32'(tx_data_o), 32'h00);
        check("rst_busy",  32'(busy_o),    32'd0);
        check("rst_fd",    32'(frame_done_o), 32'd0);
        rst = 1'b0;

        // Idle with no samples, including a stray done pulse
        repeat (20) @(negedge clk);
        spur_req = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_ready", 32'(s_ready_o), 32'd1);
        check("idle_busy",  32'(busy_o),    32'd0);
        check("idle_no_en", 32'(en_cnt),    32'd0);

        // Frame 1: back-to-back samples, header latency
        push_frame();
        send(16'h1234, 16'hABCD);
        check("hdr_lat_c1", 32'(tx_en_o), 32'd0);
        @(negedge clk);
        check("hdr_lat_c2", 32'(tx_en_o), 32'd0);
        @(negedge clk);
        check("hdr_lat_en",   32'(tx_en_o),   32'd1);
        check("hdr_lat_data", 32'(tx_data_o), 32'hAA);
        send(16'h0001, 16'hFFFF);
        wait_frames(1);
        check("frame1_len", 32'(en_cnt), 32'(FRAME_LEN));

        // Frame 2: second sample arrives late
        push_frame();
        d0 = done_cnt;
        send(16'h1234, 16'hABCD);
        for (int k = 0; k < 1000; k++) begin
            if (done_cnt >= d0 + 5) break;
            @(negedge clk);
        end
        check("sample1_done", 32'(done_cnt >= d0 + 5), 32'd1);
        e0 = en_cnt;
        repeat (100) @(negedge clk);
        check("starve_no_en", 32'(en_cnt - e0), 32'd0);
        check("starve_busy",  32'(busy_o),      32'd1);
        send(16'h0001, 16'hFFFF);
        wait_frames(2);

        // Frame 3: stray done pulse right after every real one
        push_frame();
        e0 = en_cnt;
        spur_after = 1'b1;
        send(16'h1234, 16'hABCD);
        send(16'h0001, 16'hFFFF);
        wait_frames(3);
        spur_after = 1'b0;
        check("spur_len", 32'(en_cnt - e0), 32'(FRAME_LEN));

        // Reset after the third byte of a frame
        exp_q.push_back(8'hAA); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        e0 = en_cnt;
        send(16'h1234, 16'hABCD);
        for (int k = 0; k < 1000; k++) begin
            if (en_cnt >= e0 + 3) break;
            @(negedge clk);
        end
        check("pre_rst_bytes", 32'(en_cnt - e0), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", 32'(s_ready_o), 32'd1);
        check("mid_rst_en",    32'(tx_en_o),   32'd0);
        check("mid_rst_data",  32'(tx_data_o), 32'h00);
        check("mid_rst_busy",  32'(busy_o),    32'd0);
        check("mid_rst_fd",    32'(frame_done_o), 32'd0);
        repeat (30) @(negedge clk);
        check("post_rst_quiet", 32'(en_cnt - e0), 32'd3);

        // Frame 4: fresh frame after the abandoned one
        push_frame();
        send(16'h1234, 16'hABCD);
        send(16'h0001, 16'hFFFF);
        wait_frames(4);
        repeat (10) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_frames",      32'(fd_cnt),       32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
